// File: rtl/caliptra_prim_alert_ping_sched.sv
// Round-robin ping scheduler for the alert receivers: pings one enabled channel at a time,
// waits for its acknowledge and flags channels that miss their response window.
module caliptra_prim_alert_ping_sched #(
  parameter int unsigned NumAlerts = 4,
  parameter int unsigned WaitW     = 24,
  parameter int unsigned TimeoutW  = 16,
  parameter int unsigned IdxW      = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NumAlerts-1:0] alert_en_i,
  input  logic [WaitW-1:0]     wait_cyc_i,
  input  logic [TimeoutW-1:0]  timeout_cyc_i,
  input  logic                 clr_fail_i,
  input  logic [NumAlerts-1:0] ping_ok_i,
  output logic [NumAlerts-1:0] ping_req_o,
  output logic                 ping_fail_o,
  output logic [IdxW-1:0]      ping_fail_idx_o,
  output logic [NumAlerts-1:0] alert_fail_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StWait, StPing} state_e;

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wcnt_q, wcnt_d;
  logic [TimeoutW-1:0]   tcnt_q, tcnt_d;
  logic [IdxW-1:0]       cur_idx_q, cur_idx_d;
  logic [IdxW-1:0]       last_idx_q, last_idx_d;
  logic [NumAlerts-1:0]  alert_fail_q, alert_fail_d;
  logic                  ping_fail_q;
  logic [IdxW-1:0]       ping_fail_idx_q;
  logic                  fail_set;
  logic [IdxW-1:0]       sel_idx;
  logic [IdxW-1:0]       cand;

  // Walk candidates from farthest to nearest so the nearest enabled channel after
  // last_idx is the one left in sel_idx.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int i = int'(NumAlerts); i >= 1; i--) begin
      cand = IdxW'((int'(last_idx_q) + i) % int'(NumAlerts));
      if (alert_en_i[cand]) begin
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    fail_set   = 1'b0;

    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StWait;
          wcnt_d  = wait_cyc_i;
        end
        StWait: begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WaitW'(1);
          end else if (|alert_en_i) begin
            cur_idx_d  = sel_idx;
            last_idx_d = sel_idx;
            tcnt_d     = timeout_cyc_i;
            state_d    = StPing;
          end else begin
            wcnt_d = wait_cyc_i;
          end
        end
        StPing: begin
          if (!alert_en_i[cur_idx_q] || ping_ok_i[cur_idx_q]) begin
            state_d = StWait;
            wcnt_d  = wait_cyc_i;
          end else if (tcnt_q == '0) begin
            fail_set = 1'b1;
            state_d  = StWait;
            wcnt_d   = wait_cyc_i;
          end else begin
            tcnt_d = tcnt_q - TimeoutW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A new failure wins over a simultaneous clear for its own bit.
  always_comb begin
    alert_fail_d = clr_fail_i ? '0 : alert_fail_q;
    if (fail_set) begin
      alert_fail_d[cur_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      wcnt_q          <= '0;
      tcnt_q          <= '0;
      cur_idx_q       <= '0;
      last_idx_q      <= IdxW'(NumAlerts - 1);
      alert_fail_q    <= '0;
      ping_fail_q     <= 1'b0;
      ping_fail_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      tcnt_q          <= tcnt_d;
      cur_idx_q       <= cur_idx_d;
      last_idx_q      <= last_idx_d;
      alert_fail_q    <= alert_fail_d;
      ping_fail_q     <= fail_set;
      ping_fail_idx_q <= fail_set ? cur_idx_q : '0;
    end
  end

  always_comb begin
    ping_req_o = '0;
    if (state_q == StPing) begin
      ping_req_o[cur_idx_q] = 1'b1;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign ping_fail_o     = ping_fail_q;
  assign ping_fail_idx_o = ping_fail_idx_q;
  assign alert_fail_o    = alert_fail_q;

endmodule

// File: tb/tb_caliptra_prim_alert_ping_sched.sv
// Bench for caliptra_prim_alert_ping_sched: directed ping table, hand-written abort/reset
// sequences and a randomized transaction-level reference model.
module tb_caliptra_prim_alert_ping_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  alert_en;
  logic [23:0] wait_cyc;
  logic [15:0] tmo_cyc;
  logic        clr;
  logic [3:0]  ping_ok;
  logic [3:0]  ping_req;
  logic        ping_fail;
  logic [1:0]  ping_fail_idx;
  logic [3:0]  alert_fail;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  caliptra_prim_alert_ping_sched dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .alert_en_i      (alert_en),
    .wait_cyc_i      (wait_cyc),
    .timeout_cyc_i   (tmo_cyc),
    .clr_fail_i      (clr),
    .ping_ok_i       (ping_ok),
    .ping_req_o      (ping_req),
    .ping_fail_o     (ping_fail),
    .ping_fail_idx_o (ping_fail_idx),
    .alert_fail_o    (alert_fail),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] aen;
    int         tmo;
    int         ack;   // PING cycle (1-based) carrying the ack, 0 = never
    bit         clr;
    int         ch;
    int         len;
    int         gap;
    bit         fail;
    logic [3:0] af;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        idx = i;
        cnt++;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic wait_req(output int ch, output int gap);
    gap = 0;
    while (ping_req == 4'b0 && gap < 1000) begin
      gap++;
      @(negedge clk);
    end
    if (ping_req == 4'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL req_wait: no ping_req within %0d cycles", gap);
      ch = -1;
    end else begin
      ch = onehot_idx(ping_req);
    end
  endtask

  // Entered at a negedge; returns at the negedge of the first cycle after the ping.
  task automatic run_ping(input int ack_at, input bit clr_v, input bit noise,
                          output int ch, output int len, output int gap);
    logic [3:0] other;
    wait_req(ch, gap);
    len = 0;
    while (ping_req != 4'b0 && len < 100) begin
      len++;
      other   = 4'($urandom()) & ~ping_req;
      ping_ok = noise ? other : 4'b0;
      if (len == ack_at) ping_ok = ping_ok | ping_req;
      clr = clr_v;
      @(negedge clk);
    end
    ping_ok = 4'b0;
    clr     = 1'b0;
  endtask

  function automatic int next_ch(input int last, input logic [3:0] aen);
    for (int i = 1; i <= 4; i++) begin
      if (aen[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  initial begin
    vec_t       tbl[15];
    int         ch, len, gap;
    int         last, prev_wait, exp_ch, exp_len;
    bit         exp_fail;
    logic [3:0] maf;

    tbl[0]  = '{4'hF, 5, 2, 0, 0, 2, 4, 0, 4'b0000};
    tbl[1]  = '{4'hF, 5, 2, 0, 1, 2, 3, 0, 4'b0000};
    tbl[2]  = '{4'hF, 5, 2, 0, 2, 2, 3, 0, 4'b0000};
    tbl[3]  = '{4'hF, 5, 2, 0, 3, 2, 3, 0, 4'b0000};
    tbl[4]  = '{4'hF, 5, 2, 0, 0, 2, 3, 0, 4'b0000};
    tbl[5]  = '{4'hF, 5, 2, 0, 1, 2, 3, 0, 4'b0000};
    tbl[6]  = '{4'hF, 3, 0, 0, 2, 4, 3, 1, 4'b0100};
    tbl[7]  = '{4'hF, 5, 2, 0, 3, 2, 3, 0, 4'b0100};
    tbl[8]  = '{4'hA, 5, 2, 0, 1, 2, 3, 0, 4'b0100};
    tbl[9]  = '{4'hA, 5, 2, 0, 3, 2, 3, 0, 4'b0100};
    tbl[10] = '{4'hA, 5, 2, 0, 1, 2, 3, 0, 4'b0100};
    tbl[11] = '{4'hA, 5, 2, 0, 3, 2, 3, 0, 4'b0100};
    tbl[12] = '{4'hA, 2, 3, 0, 1, 3, 3, 0, 4'b0100};  // ack on the tcnt=0 cycle
    tbl[13] = '{4'hF, 0, 0, 0, 2, 1, 3, 1, 4'b0100};  // zero timeout, no ack
    tbl[14] = '{4'h2, 0, 0, 1, 1, 1, 3, 1, 4'b0010};  // clear and new fail together

    rst = 1'b1; en = 1'b0; alert_en = 4'b0; ping_ok = 4'b0;
    wait_cyc = 24'd2; tmo_cyc = 16'd5; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ping_req", 32'(ping_req), 32'd0);
    check("reset ping_fail", 32'(ping_fail), 32'd0);
    check("reset fail_idx", 32'(ping_fail_idx), 32'd0);
    check("reset alert_fail", 32'(alert_fail), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    for (int r = 0; r < 15; r++) begin
      alert_en = tbl[r].aen;
      tmo_cyc  = 16'(tbl[r].tmo);
      run_ping(tbl[r].ack, tbl[r].clr, 1'b0, ch, len, gap);
      check($sformatf("row%0d channel", r), 32'(ch), 32'(tbl[r].ch));
      check($sformatf("row%0d req_len", r), 32'(len), 32'(tbl[r].len));
      check($sformatf("row%0d gap", r), 32'(gap), 32'(tbl[r].gap));
      check($sformatf("row%0d ping_fail", r), 32'(ping_fail), 32'(tbl[r].fail));
      if (tbl[r].fail) check($sformatf("row%0d fail_idx", r), 32'(ping_fail_idx), 32'(tbl[r].ch));
      check($sformatf("row%0d alert_fail", r), 32'(alert_fail), 32'(tbl[r].af));
    end

    // No channel enabled: stays in WAIT without pinging.
    alert_en = 4'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("none_en ping_req", 32'(ping_req), 32'd0);
      check("none_en busy", 32'(busy), 32'd1);
    end
    alert_en = 4'hF;
    tmo_cyc  = 16'd5;
    run_ping(2, 1'b0, 1'b0, ch, len, gap);
    check("after_none channel", 32'(ch), 32'd2);

    // Scheduler disable on the 2nd PING cycle.
    wait_req(ch, gap);
    check("en_abort channel", 32'(ch), 32'd3);
    @(negedge clk);
    check("en_abort req_2nd", 32'(ping_req), 32'b1000);
    en = 1'b0;
    @(negedge clk);
    check("en_abort ping_req", 32'(ping_req), 32'd0);
    check("en_abort busy", 32'(busy), 32'd0);
    check("en_abort ping_fail", 32'(ping_fail), 32'd0);
    en = 1'b1;
    run_ping(2, 1'b0, 1'b0, ch, len, gap);
    check("after_en_abort channel", 32'(ch), 32'd0);
    check("after_en_abort gap", 32'(gap), 32'd4);

    // Channel disable while pinged.
    wait_req(ch, gap);
    check("ch_abort channel", 32'(ch), 32'd1);
    alert_en = 4'b1101;
    @(negedge clk);
    check("ch_abort ping_req", 32'(ping_req), 32'd0);
    check("ch_abort busy", 32'(busy), 32'd1);
    check("ch_abort ping_fail", 32'(ping_fail), 32'd0);
    alert_en = 4'hF;
    run_ping(2, 1'b0, 1'b0, ch, len, gap);
    check("after_ch_abort channel", 32'(ch), 32'd2);
    check("after_ch_abort gap", 32'(gap), 32'd3);
    check("after_ch_abort alert_fail", 32'(alert_fail), 32'b0010);

    // Reset during PING.
    wait_req(ch, gap);
    check("rst_ping channel", 32'(ch), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ping ping_req", 32'(ping_req), 32'd0);
    check("rst_ping ping_fail", 32'(ping_fail), 32'd0);
    check("rst_ping alert_fail", 32'(alert_fail), 32'd0);
    check("rst_ping busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run_ping(2, 1'b0, 1'b0, ch, len, gap);
    check("after_rst channel", 32'(ch), 32'd0);
    check("after_rst gap", 32'(gap), 32'd4);

    // Randomized transactions against a ping-level model.
    last = 0; prev_wait = 2; maf = 4'b0;
    for (int it = 0; it < 60; it++) begin
      int         w, t, a;
      bit         c;
      logic [3:0] aen;
      aen = 4'($urandom_range(1, 15));
      t   = $urandom_range(0, 4);
      w   = $urandom_range(0, 5);
      a   = $urandom_range(0, t + 2);
      c   = ($urandom_range(0, 3) == 0);
      alert_en = aen;
      tmo_cyc  = 16'(t);
      wait_cyc = 24'(w);
      exp_ch   = next_ch(last, aen);
      exp_fail = !(a != 0 && a <= t + 1);
      exp_len  = exp_fail ? t + 1 : a;
      run_ping(a, c, 1'b1, ch, len, gap);
      if (c) maf = 4'b0;
      if (exp_fail) maf[exp_ch] = 1'b1;
      check($sformatf("rnd%0d channel", it), 32'(ch), 32'(exp_ch));
      check($sformatf("rnd%0d req_len", it), 32'(len), 32'(exp_len));
      check($sformatf("rnd%0d gap", it), 32'(gap), 32'(prev_wait + 1));
      check($sformatf("rnd%0d ping_fail", it), 32'(ping_fail), 32'(exp_fail));
      if (exp_fail) check($sformatf("rnd%0d fail_idx", it), 32'(ping_fail_idx), 32'(exp_ch));
      check($sformatf("rnd%0d alert_fail", it), 32'(alert_fail), 32'(maf));
      last      = exp_ch;
      prev_wait = w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
